// File: rtl/vga_rx.sv
// vga_rx: receiving end of the VGA video interface.
//
// Registers hsync/vsync/RGB444 on the pixel clock. From the registered syncs it
// recovers pixel coordinates and a pixel-valid strobe, measures line and frame
// length, and reports lock once timing is stable. The pixel stream stays gated
// off until the receiver is locked.
//
// Ports:
//   clk          pixel clock, all logic on posedge
//   reset        synchronous, active-high reset
//   hsync/vsync  received syncs (idle level H_POL/V_POL, pulse is the inverse)
//   rgb          received pixel, RGB444 {R[11:8], G[7:4], B[3:0]}
//   pixel_data   registered pixel, 2 clocks after rgb
//   pixel_x/y    column/row of pixel_data inside the active area
//   pixel_valid  pixel_data/x/y valid this cycle
//   frame_start  one-cycle pulse with the pixel at x=0, y=0
//   locked       timing stable for the last full frame
//   lock_lost    one-cycle pulse on the locked -> unlocked transition
//   h_total      last measured clocks per line
//   v_total      last measured lines per frame
module vga_rx #(
    parameter int   SCREEN_WIDTH  = 640,
    parameter int   SCREEN_HEIGHT = 480,
    parameter int   H_BP          = 48,
    parameter int   V_BP          = 33,
    parameter logic H_POL         = 1'b1,
    parameter logic V_POL         = 1'b1,
    parameter int   CW            = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hsync,
    input  logic          vsync,
    input  logic [11:0]   rgb,
    output logic [11:0]   pixel_data,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          pixel_valid,
    output logic          frame_start,
    output logic          locked,
    output logic          lock_lost,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total
);

    typedef enum logic [1:0] {UNLOCKED, MEASURE, LOCKED} state_e;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] H_LO    = CW'(H_BP);
    localparam logic [CW-1:0] H_HI    = CW'(H_BP + SCREEN_WIDTH);
    localparam logic [CW-1:0] V_LO    = CW'(V_BP);
    localparam logic [CW-1:0] V_HI    = CW'(V_BP + SCREEN_HEIGHT);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] val);
        return (val == CNT_MAX) ? val : val + ONE;
    endfunction

    // Input stage and previous-sample registers.
    logic          s_hs_q, s_vs_q, p_hs_q, p_vs_q;
    logic [11:0]   s_rgb_q;

    // Position, measurement and FSM state.
    logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic          v_pend_q, v_pend_d;
    logic [CW-1:0] lcnt_q, lcnt_d, fcnt_q, fcnt_d;
    logic [CW-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
    logic          h_seen_q, h_seen_d, v_seen_q, v_seen_d;
    state_e        state_q, state_d;
    logic          mismatch_q, mismatch_d;

    // Output stage.
    logic [11:0]   pix_data_q, pix_data_d;
    logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic          pix_valid_q, pix_valid_d;
    logic          frame_start_q, frame_start_d;
    logic          lock_lost_q, lock_lost_d;

    logic          h_start, h_end, v_start, v_end, active;
    logic [CW-1:0] h_period;
    logic          h_diff, v_diff, h_bad;

    assign h_start = (s_hs_q != H_POL) && (p_hs_q == H_POL);
    assign h_end   = (s_hs_q == H_POL) && (p_hs_q != H_POL);
    assign v_start = (s_vs_q != V_POL) && (p_vs_q == V_POL);
    assign v_end   = (s_vs_q == V_POL) && (p_vs_q != V_POL);

    // Period of the line that ends at this h_start.
    assign h_period = lcnt_q + ONE;
    assign h_diff   = (h_period != h_total_q);
    assign v_diff   = (fcnt_q != v_total_q);
    // A line that cannot be trusted while measuring: no reference yet, or different.
    assign h_bad    = h_start && ((h_total_q == '0) || h_diff);

    assign active = (hcnt_q >= H_LO) && (hcnt_q < H_HI) &&
                    (vcnt_q >= V_LO) && (vcnt_q < V_HI);

    // Lock FSM next state.
    always_comb begin
        // NOTE: every _d is given its hold value first, so no path through the
        // block leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        mismatch_d = mismatch_q;
        case (state_q)
            UNLOCKED: begin
                if (v_start) begin
                    state_d    = MEASURE;
                    mismatch_d = 1'b0;
                end
            end
            MEASURE: begin
                if (v_start) begin
                    // A coincident h_start closes the last line of this frame,
                    // so its verdict counts towards this decision.
                    if (!(mismatch_q || h_bad) && (v_total_q != '0) && !v_diff)
                        state_d = LOCKED;
                    mismatch_d = 1'b0;
                end else if (h_bad) begin
                    mismatch_d = 1'b1;
                end
            end
            LOCKED: begin
                if ((h_start && h_diff) || (v_start && v_diff))
                    state_d = UNLOCKED;
            end
            default: state_d = UNLOCKED;
        endcase
    end

    // Counters, measurements and output stage next state.
    always_comb begin
        hcnt_d = h_end ? '0 : sat_inc(hcnt_q);

        // Frame start is deferred to the next line end so vcnt changes on a
        // line boundary.
        vcnt_d   = vcnt_q;
        v_pend_d = v_pend_q;
        if (h_end) begin
            if (v_pend_q) begin
                vcnt_d   = '0;
                v_pend_d = 1'b0;
            end else begin
                vcnt_d = sat_inc(vcnt_q);
            end
        end
        if (v_end)
            v_pend_d = 1'b1;

        lcnt_d    = sat_inc(lcnt_q);
        h_seen_d  = h_seen_q;
        h_total_d = h_total_q;
        if (h_start) begin
            lcnt_d   = '0;
            h_seen_d = 1'b1;
            if (h_seen_q)
                h_total_d = h_period;
        end

        fcnt_d    = h_start ? sat_inc(fcnt_q) : fcnt_q;
        v_seen_d  = v_seen_q;
        v_total_d = v_total_q;
        if (v_start) begin
            // A coincident h_start is the first line of the new frame.
            fcnt_d   = h_start ? ONE : '0;
            v_seen_d = 1'b1;
            if (v_seen_q)
                v_total_d = fcnt_q;
        end

        // Gate on the next state so pixel_valid drops the cycle after lock loss.
        pix_valid_d = active && (state_d == LOCKED);
        pix_data_d  = pix_data_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        if (pix_valid_d) begin
            pix_data_d = s_rgb_q;
            pix_x_d    = hcnt_q - H_LO;
            pix_y_d    = vcnt_q - V_LO;
        end
        frame_start_d = pix_valid_d && (hcnt_q == H_LO) && (vcnt_q == V_LO);
        lock_lost_d   = (state_q == LOCKED) && (state_d == UNLOCKED);
    end

    // NOTE: non-blocking assignments, so every register samples the pre-edge
    // value of its sources regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Previous samples park at the idle level: no spurious edge after reset.
            s_hs_q        <= H_POL;
            s_vs_q        <= V_POL;
            p_hs_q        <= H_POL;
            p_vs_q        <= V_POL;
            s_rgb_q       <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            v_pend_q      <= 1'b0;
            lcnt_q        <= '0;
            fcnt_q        <= '0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            state_q       <= UNLOCKED;
            mismatch_q    <= 1'b0;
            pix_data_q    <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            lock_lost_q   <= 1'b0;
        end else begin
            s_hs_q        <= hsync;
            s_vs_q        <= vsync;
            p_hs_q        <= s_hs_q;
            p_vs_q        <= s_vs_q;
            s_rgb_q       <= rgb;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            v_pend_q      <= v_pend_d;
            lcnt_q        <= lcnt_d;
            fcnt_q        <= fcnt_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            h_seen_q      <= h_seen_d;
            v_seen_q      <= v_seen_d;
            state_q       <= state_d;
            mismatch_q    <= mismatch_d;
            pix_data_q    <= pix_data_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            lock_lost_q   <= lock_lost_d;
        end
    end

    assign pixel_data  = pix_data_q;
    assign pixel_x     = pix_x_q;
    assign pixel_y     = pix_y_q;
    assign pixel_valid = pix_valid_q;
    assign frame_start = frame_start_q;
    assign locked      = (state_q == LOCKED);
    assign lock_lost   = lock_lost_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;

endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: directed bench for vga_rx on a reduced video mode.
//
// Mode: 8x4 active, 16 clocks/line (hsync pulse gx 0..1), 10 lines/frame
// (vsync pulse gy 0..1, starting together with the hsync pulse), H_BP=3,
// V_BP=2. rgb carries {gy[5:0], gx[5:0]} so every pixel is identifiable.
// Two instances run side by side: positive syncs and inverted syncs with
// H_POL=V_POL=0. Both must give identical results.
//
// Hand-derived mapping: hsync goes idle at gx=2, hcnt=0 pairs with the gx=3
// sample, so x=0 is the gx=6 sample; vcnt=0 is line gy=2, so y=0 is gy=4.
// First pixel data = {4,6} = 12'h106, last (x=7,y=3) = {7,13} = 12'h1CD.
// After reset the first v_start only restarts the frame counter and the
// second only loads v_total, so lock comes at the third v_start.
module tb_vga_rx;
    localparam int W   = 8;
    localparam int H   = 4;
    localparam int HBP = 3;
    localparam int VBP = 2;
    localparam int CW  = 12;
    localparam int HT  = 16;
    localparam int VT  = 10;
    localparam int HPW = 2;
    localparam int VPW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, hsync, vsync;
    logic        hsync_n, vsync_n;
    logic [11:0] rgb;
    assign hsync_n = ~hsync;
    assign vsync_n = ~vsync;

    logic [11:0]   pd [2];
    logic [CW-1:0] px [2], py [2], ht [2], vt [2];
    logic          pv [2], fs [2], lk [2], ll [2];

    vga_rx #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .H_BP(HBP), .V_BP(VBP),
             .H_POL(1'b1), .V_POL(1'b1), .CW(CW)) dut_pos (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .pixel_data(pd[0]), .pixel_x(px[0]), .pixel_y(py[0]),
        .pixel_valid(pv[0]), .frame_start(fs[0]), .locked(lk[0]),
        .lock_lost(ll[0]), .h_total(ht[0]), .v_total(vt[0]));

    vga_rx #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .H_BP(HBP), .V_BP(VBP),
             .H_POL(1'b0), .V_POL(1'b0), .CW(CW)) dut_neg (
        .clk(clk), .reset(reset), .hsync(hsync_n), .vsync(vsync_n), .rgb(rgb),
        .pixel_data(pd[1]), .pixel_x(px[1]), .pixel_y(py[1]),
        .pixel_valid(pv[1]), .frame_start(fs[1]), .locked(lk[1]),
        .lock_lost(ll[1]), .h_total(ht[1]), .v_total(vt[1]));

    int checks = 0;
    int errors = 0;

    int            n_valid [2], n_fs [2], n_lost [2], ex [2], ey [2];
    logic [CW-1:0] ht6 [2], ht7 [2];
    logic [11:0]   last_rgb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of generator output at (gx, gy), then sample both instances.
    task automatic step(input logic rst, input int gx, input int gy);
        last_rgb = rgb;
        reset    = rst;
        hsync    = (gx >= HPW);
        vsync    = (gy >= VPW);
        rgb      = {6'(gy), 6'(gx)};
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst)
                check($sformatf("reset_outputs%0d", i),
                      {pd[i], px[i], py[i], pv[i], fs[i], lk[i], ll[i], ht[i], vt[i]}, 64'd0);
            if (ll[i])
                n_lost[i]++;
            if (fs[i]) begin
                check($sformatf("fs_valid%0d", i), 64'(pv[i]), 64'd1);
                check($sformatf("fs_xy%0d", i), {px[i], py[i]}, 64'd0);
                check($sformatf("first_data%0d", i), 64'(pd[i]), 64'h106);
                ex[i] = 0;
                ey[i] = 0;
                n_fs[i]++;
            end
            if (pv[i]) begin
                n_valid[i]++;
                check($sformatf("data_delay%0d", i), 64'(pd[i]), 64'(last_rgb));
                check($sformatf("raster_xy%0d", i), {px[i], py[i]}, {CW'(ex[i]), CW'(ey[i])});
                if (ex[i] == W - 1 && ey[i] == H - 1)
                    check($sformatf("last_data%0d", i), 64'(pd[i]), 64'h1CD);
                ex[i]++;
                if (ex[i] == W) begin
                    ex[i] = 0;
                    ey[i]++;
                end
            end
            if (gy == 6 && gx == 3) ht6[i] = ht[i];
            if (gy == 7 && gx == 3) ht7[i] = ht[i];
        end
    endtask

    // One frame (or the tail of one) with optional stretched line and reset pulse.
    task automatic run_frame(input int lines, input int stretch_y, input int rst_y,
                             input int rst_x, input int start_y, input int start_x);
        for (int i = 0; i < 2; i++) begin
            n_valid[i] = 0;
            n_fs[i]    = 0;
            n_lost[i]  = 0;
            ht6[i]     = '0;
            ht7[i]     = '0;
        end
        for (int gy = start_y; gy < lines; gy++)
            for (int gx = (gy == start_y) ? start_x : 0; gx < HT + ((gy == stretch_y) ? 1 : 0); gx++)
                step((gy == rst_y) && (gx == rst_x), gx, gy);
    endtask

    task automatic frame_checks(input string name, input int e_valid, input int e_fs,
                                input int e_lost, input logic e_locked, input int e_vt);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_valid_count%0d", name, i), 64'(n_valid[i]), 64'(e_valid));
            check($sformatf("%s_frame_start%0d", name, i), 64'(n_fs[i]), 64'(e_fs));
            check($sformatf("%s_lock_lost%0d", name, i), 64'(n_lost[i]), 64'(e_lost));
            check($sformatf("%s_locked%0d", name, i), 64'(lk[i]), 64'(e_locked));
            check($sformatf("%s_v_total%0d", name, i), 64'(vt[i]), 64'(e_vt));
            check($sformatf("%s_h_total%0d", name, i), 64'(ht[i]), 64'd16);
        end
    endtask

    initial begin
        reset = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        rgb   = '0;
        for (int i = 0; i < 2; i++) begin
            ex[i] = 0;
            ey[i] = 0;
        end

        // Reset mid-frame, then run the remainder of that frame.
        run_frame(VT, -1, 5, 4, 5, 4);
        frame_checks("tail", 0, 0, 0, 1'b0, 0);

        // First v_start: restart only. Second: v_total loaded, still no lock.
        run_frame(VT, -1, -1, -1, 0, 0);
        frame_checks("frame_a", 0, 0, 0, 1'b0, 0);
        run_frame(VT, -1, -1, -1, 0, 0);
        frame_checks("frame_b", 0, 0, 0, 1'b0, 10);

        // Third v_start locks: a full frame of pixels.
        run_frame(VT, -1, -1, -1, 0, 0);
        frame_checks("locked_c", W * H, 1, 0, 1'b1, 10);

        // Line gy=5 stretched to 17 clocks: lock lost at the h_start of gy=6,
        // after lines 4 and 5 have been delivered.
        run_frame(VT, 5, -1, -1, 0, 0);
        frame_checks("stretch_d", 2 * W, 1, 1, 1'b0, 10);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("stretch_period%0d", i), 64'(ht6[i]), 64'd17);
            check($sformatf("stretch_recover%0d", i), 64'(ht7[i]), 64'd16);
        end
        run_frame(VT, -1, -1, -1, 0, 0);
        frame_checks("measure_e", 0, 0, 0, 1'b0, 10);
        run_frame(VT, -1, -1, -1, 0, 0);
        frame_checks("relock_f", W * H, 1, 0, 1'b1, 10);

        // Short frame (9 lines): pixels still delivered, lock lost at next v_start.
        run_frame(VT - 1, -1, -1, -1, 0, 0);
        frame_checks("short_g", W * H, 1, 0, 1'b1, 10);
        run_frame(VT, -1, -1, -1, 0, 0);
        frame_checks("after_short_h", 0, 0, 1, 1'b0, 9);
        run_frame(VT, -1, -1, -1, 0, 0);
        frame_checks("measure_i", 0, 0, 0, 1'b0, 10);
        run_frame(VT, -1, -1, -1, 0, 0);
        frame_checks("relock_j", W * H, 1, 0, 1'b1, 10);

        // One-cycle reset mid-line at gy=5, gx=8: line 4 plus the gx=6 pixel of
        // line 5 get out; the first h_start afterwards leaves h_total at 0.
        run_frame(VT, -1, 5, 8, 0, 0);
        frame_checks("reset_k", W + 1, 1, 0, 1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_first_h%0d", i), 64'(ht6[i]), 64'd0);
            check($sformatf("reset_second_h%0d", i), 64'(ht7[i]), 64'd16);
        end
        run_frame(VT, -1, -1, -1, 0, 0);
        frame_checks("reset_l", 0, 0, 0, 1'b0, 0);
        run_frame(VT, -1, -1, -1, 0, 0);
        frame_checks("reset_m", 0, 0, 0, 1'b0, 10);
        run_frame(VT, -1, -1, -1, 0, 0);
        frame_checks("relock_n", W * H, 1, 0, 1'b1, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
